// File: rtl/imem_loader.sv
// Boot loader: byte stream -> big-endian 32-bit words -> instruction memory from address 0; holds the core in reset until the image loads.
// Latency: a word is written the cycle after its 4th byte; done and cpu_rst_n rise the cycle after the final write.
// Backpressure: in_ready is 1 while a frame is open (one byte per cycle, no stalls) and 0 in DONE/ERR.
//
// Ports: clk, rst (async active-low); in_valid/in_data/in_ready byte stream;
//        reload pulse (acts only in DONE/ERR); imem_wren/imem_addr/imem_data memory write port;
//        cpu_rst_n core reset; done/error status.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte (CHK state).
module imem_loader #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              reload,
    output logic              imem_wren,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_data,
    output logic              cpu_rst_n,
    output logic              done,
    output logic              error
);

    localparam logic [2:0] S_HDR_HI = 3'd0;
    localparam logic [2:0] S_HDR_LO = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHK    = 3'd3;
`endif
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd5;

    logic [2:0]  state;
    logic [15:0] count;      // word count from the header
    logic [15:0] word_idx;   // index of the next word to write
    logic [1:0]  byte_idx;   // byte position inside the current word
    logic [23:0] shift_lo;   // first three bytes of the word being assembled
    // Set after the last word's 4th byte when no checksum follows: parks DATA
    // for the write-pulse cycle so DONE starts the cycle after that pulse.
    logic        fin;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    logic        xfer;
    logic [15:0] hdr_full;

    assign xfer     = in_valid & in_ready;
    assign hdr_full = {count[15:8], in_data};

    always_comb begin
        in_ready = 1'b0;
        case (state)
            S_HDR_HI, S_HDR_LO: in_ready = 1'b1;
            S_DATA:             in_ready = ~fin;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK:              in_ready = 1'b1;
`endif
            default:            in_ready = 1'b0;
        endcase
    end

    assign done      = (state == S_DONE);
    assign error     = (state == S_ERR);
    assign cpu_rst_n = (state == S_DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_HDR_HI;
            count     <= '0;
            word_idx  <= '0;
            byte_idx  <= '0;
            shift_lo  <= '0;
            fin       <= 1'b0;
            imem_wren <= 1'b0;
            imem_addr <= '0;
            imem_data <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            imem_wren <= 1'b0;
            case (state)
                S_HDR_HI: begin
                    if (xfer) begin
                        count[15:8] <= in_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum        <= csum ^ in_data;
`endif
                        state       <= S_HDR_LO;
                    end
                end
                S_HDR_LO: begin
                    if (xfer) begin
                        count[7:0] <= in_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum       <= csum ^ in_data;
`endif
                        if (hdr_full == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state <= S_CHK;
`else
                            state <= S_DONE;
`endif
                        end else if ({16'd0, hdr_full} > 32'(DEPTH)) begin
                            state <= S_ERR;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (fin) begin
                        fin   <= 1'b0;
                        state <= S_DONE;
                    end else if (xfer) begin
                        shift_lo <= {shift_lo[15:0], in_data};
                        byte_idx <= byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum     <= csum ^ in_data;
`endif
                        if (byte_idx == 2'd3) begin
                            imem_wren <= 1'b1;
                            imem_addr <= ADDR_W'(word_idx);
                            imem_data <= {shift_lo, in_data};
                            word_idx  <= word_idx + 16'd1;
                            if (word_idx == count - 16'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state <= S_CHK;
`else
                                fin   <= 1'b1;
`endif
                            end
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (xfer) begin
                        state <= (in_data == csum) ? S_DONE : S_ERR;
                    end
                end
`endif
                S_DONE, S_ERR: begin
                    if (reload) begin
                        state    <= S_HDR_HI;
                        count    <= '0;
                        word_idx <= '0;
                        byte_idx <= '0;
                        shift_lo <= '0;
                        fin      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum     <= '0;
`endif
                    end
                end
                default: state <= S_HDR_HI;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1024;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              reload = 1'b0;
    logic              imem_wren;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic              cpu_rst_n;
    logic              done;
    logic              error;

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .reload(reload),
        .imem_wren(imem_wren), .imem_addr(imem_addr), .imem_data(imem_data),
        .cpu_rst_n(cpu_rst_n), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_writes = 0;

    // Scoreboard: {addr, data} of each expected write, pushed when the 4th byte is driven.
    logic [ADDR_W+31:0] exp_q[$];
    logic [31:0]        fw[$];   // words of the frame being sent

    // Memory-write monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (imem_wren === 1'b1) begin
            logic [ADDR_W+31:0] e;
            n_writes++;
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL write_unexpected: got addr=%0d data=%08h, required no write", imem_addr, imem_data);
            end else begin
                e = exp_q.pop_front();
                if ({imem_addr, imem_data} !== e)
                    $display("FAIL write_match: got addr=%0d data=%08h, required addr=%0d data=%08h",
                             imem_addr, imem_data, e[ADDR_W+31:32], e[31:0]);
                else
                    n_pass++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Drives one byte at a falling edge; it transfers on the next rising edge.
    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Sends header then the words in fw, with 'gap' idle cycles between bytes.
    task automatic send_frame(input logic [15:0] cnt, input int gap);
        logic [7:0] bytes[$];
        logic [31:0] w;
        bytes.push_back(cnt[15:8]);
        bytes.push_back(cnt[7:0]);
        foreach (fw[i]) begin
            w = fw[i];
            bytes.push_back(w[31:24]);
            bytes.push_back(w[23:16]);
            bytes.push_back(w[15:8]);
            bytes.push_back(w[7:0]);
        end
        foreach (bytes[i]) begin
            if (i >= 2 && ((i - 2) % 4) == 3)
                exp_q.push_back({ADDR_W'((i - 2) / 4), fw[(i - 2) / 4]});
            send_byte(bytes[i]);
            if (i != bytes.size() - 1)
                repeat (gap) @(negedge clk);
        end
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b, required 1", in_ready); else n_pass++;
        n_total++; if (imem_wren !== 1'b0) $display("FAIL rst_wren: got %b, required 0", imem_wren); else n_pass++;
        n_total++; if (imem_addr !== '0) $display("FAIL rst_addr: got %0d, required 0", imem_addr); else n_pass++;
        n_total++; if (imem_data !== 32'h0) $display("FAIL rst_data: got %08h, required 0", imem_data); else n_pass++;
        n_total++; if ({cpu_rst_n, done, error} !== 3'b000)
            $display("FAIL rst_status: got cpu_rst_n/done/error=%b, required 000", {cpu_rst_n, done, error});
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Two-word frame with 'gap' idle cycles between bytes, starting from HDR_HI.
    task automatic run_two_word(input string tag, input int gap);
        int w0;
        w0 = n_writes;
        fw = '{32'hDEADBEEF, 32'h12345678};
        send_frame(16'd2, gap);
        n_total++; if (imem_wren !== 1'b1 || done !== 1'b0)
            $display("FAIL %s_last_write: got wren=%b done=%b, required wren=1 done=0", tag, imem_wren, done);
        else n_pass++;
        @(negedge clk);
        n_total++; if ({done, cpu_rst_n, error, in_ready} !== 4'b1100)
            $display("FAIL %s_done: got done/cpu_rst_n/error/in_ready=%b, required 1100", tag, {done, cpu_rst_n, error, in_ready});
        else n_pass++;
        repeat (3) @(negedge clk);
        n_total++; if (n_writes - w0 !== 2 || exp_q.size() != 0)
            $display("FAIL %s_write_count: got %0d writes (%0d pending), required 2", tag, n_writes - w0, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        run_two_word("b2b", 0);
    endtask

    task automatic test_gaps();
        pulse_reload();
        n_total++; if ({in_ready, done, cpu_rst_n, error} !== 4'b1000)
            $display("FAIL reload_state: got in_ready/done/cpu_rst_n/error=%b, required 1000", {in_ready, done, cpu_rst_n, error});
        else n_pass++;
        run_two_word("gap", 3);
    endtask

    task automatic test_overflow();
        int w0;
        pulse_reload();
        w0 = n_writes;
        send_byte(8'h04);
        send_byte(8'h01);
        n_total++; if ({error, in_ready, cpu_rst_n, done} !== 4'b1000)
            $display("FAIL ovf_err: got error/in_ready/cpu_rst_n/done=%b, required 1000", {error, in_ready, cpu_rst_n, done});
        else n_pass++;
        // Bytes offered in ERR must be ignored.
        in_valid = 1'b1; in_data = 8'hAA;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        n_total++; if (n_writes !== w0 || error !== 1'b1)
            $display("FAIL ovf_no_write: got %0d writes error=%b, required 0 writes error=1", n_writes - w0, error);
        else n_pass++;
        pulse_reload();
        fw = '{32'hCAFEBABE};
        send_frame(16'd1, 0);
        @(negedge clk);
        n_total++; if ({done, cpu_rst_n, error} !== 3'b110)
            $display("FAIL ovf_recover: got done/cpu_rst_n/error=%b, required 110", {done, cpu_rst_n, error});
        else n_pass++;
    endtask

    task automatic test_zero_count();
        int w0;
        pulse_reload();
        w0 = n_writes;
        send_byte(8'h00);
        send_byte(8'h00);
        n_total++; if ({done, cpu_rst_n, error} !== 3'b110)
            $display("FAIL zero_done: got done/cpu_rst_n/error=%b, required 110", {done, cpu_rst_n, error});
        else n_pass++;
        repeat (2) @(negedge clk);
        n_total++; if (n_writes !== w0) $display("FAIL zero_writes: got %0d, required 0", n_writes - w0); else n_pass++;
    endtask

    task automatic test_max_depth();
        pulse_reload();
        fw.delete();
        for (int i = 0; i < DEPTH; i++) fw.push_back($urandom);
        send_frame(16'(DEPTH), 0);
        n_total++; if (imem_wren !== 1'b1 || imem_addr !== ADDR_W'(DEPTH - 1))
            $display("FAIL max_last_addr: got wren=%b addr=%0d, required wren=1 addr=%0d", imem_wren, imem_addr, DEPTH - 1);
        else n_pass++;
        @(negedge clk);
        n_total++; if ({done, cpu_rst_n, error} !== 3'b110)
            $display("FAIL max_done: got done/cpu_rst_n/error=%b, required 110", {done, cpu_rst_n, error});
        else n_pass++;
        n_total++; if (exp_q.size() != 0) $display("FAIL max_pending: got %0d pending writes, required 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_midframe_reset();
        pulse_reload();
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        #2 rst = 1'b0;
        #1;
        n_total++; if ({in_ready, imem_wren, cpu_rst_n, done, error} !== 5'b10000 || imem_addr !== '0 || imem_data !== 32'h0)
            $display("FAIL midrst_outputs: got ready/wren/cpu_rst_n/done/error=%b addr=%0d data=%08h, required 10000 0 0",
                     {in_ready, imem_wren, cpu_rst_n, done, error}, imem_addr, imem_data);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_two_word("midrst", 0);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gaps();
        test_overflow();
        test_zero_count();
        test_max_depth();
        test_midframe_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader directly upstream of the single-cycle core's instruction memory.
- Accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit words, and writes them to consecutive word addresses starting at 0.
- Holds the core in reset until the image is fully loaded; the core then fetches from PC 0 (word-addressed, PC+1 stepping).

Parameters:
- ADDR_W, 10, instruction memory word-address width.
- DEPTH, 1024, maximum loadable words; must satisfy DEPTH <= 2**ADDR_W.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream byte valid.
- in_data  in  8  upstream byte.
- in_ready  out  1  loader can accept a byte; a transfer occurs when in_valid & in_ready.
- reload  in  1  single-cycle pulse; restarts the load from DONE or ERR.
- imem_wren  out  1  instruction memory write strobe, one cycle per word.
- imem_addr  out  ADDR_W  word address for the write.
- imem_data  out  32  word to write.
- cpu_rst_n  out  1  reset to the core: low while loading, high once the load succeeds.
- done  out  1  load completed successfully.
- error  out  1  load aborted.

Behaviour:
- Reset (rst low, async): state=HDR_HI, word counter=0, byte index=0, checksum=0.
- Reset output values: in_ready=1, imem_wren=0, imem_addr=0, imem_data=0, cpu_rst_n=0, done=0, error=0.
- Frame format: count[15:8], count[7:0], then count*4 data bytes with MSB first, then a checksum byte (only with the optional feature).
- State HDR_HI: accept a byte into count[15:8], then go to HDR_LO.
- State HDR_LO: accept a byte into count[7:0], then evaluate the full count:
  - count==0: go to DONE.
  - count>DEPTH: go to ERR.
  - otherwise: go to DATA.
- State DATA: shift each accepted byte into a 32-bit assembly register.
  - On the 4th byte of a word, the next cycle has imem_wren=1 for exactly one cycle, with imem_addr=word index and imem_data=the assembled word.
  - The word index then increments.
  - After the last word's 4th byte, go to DONE (or to CHK with the feature).
- in_ready stays 1 in HDR_HI, HDR_LO, DATA and CHK. Back-to-back bytes (one per cycle) are supported with no stalls.
- in_ready is 0 in DONE and ERR; in_valid is ignored there.
- DONE:
  - done=1.
  - cpu_rst_n rises on the first DONE cycle, which is the cycle after the final imem_wren pulse (or after HDR_LO when count==0).
- ERR: error=1 and cpu_rst_n=0. No further writes occur.
- reload in DONE or ERR:
  - Next cycle: state=HDR_HI, cpu_rst_n=0, done=0, error=0, counters and checksum cleared.
  - Memory contents are not cleared.
- reload in any other state is ignored.
- Idle gaps (in_valid low) at any point stall progress without loss of state.
- Async reset mid-frame abandons the frame immediately; any words already written remain in memory.
- Last word at index DEPTH-1 is written correctly; the index never wraps.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR covers every accepted header and data byte.
  - After the last data byte, state goes to CHK, which accepts one byte.
  - If the byte equals the running XOR, go to DONE; otherwise go to ERR.
  - For count==0 the path is HDR_LO -> CHK, and the expected checksum = count[15:8]^count[7:0] = 0x00.
- Undefined: no CHK state and no checksum logic; the last data byte leads directly to DONE.

Test Plan:
- Load 2 words, bytes 00 02 DE AD BE EF 12 34 56 78, sent back-to-back -> imem writes (0,0xDEADBEEF) then (1,0x12345678), one cycle each; cpu_rst_n=1 and done=1 one cycle after the 2nd write.
- Same frame with in_valid deasserted for 3 cycles between every byte -> identical writes and final state; no extra imem_wren.
- Header 0x0401 with DEPTH=1024 -> error=1 after HDR_LO, in_ready=0, no writes, cpu_rst_n=0; then reload followed by a valid 1-word frame -> done=1.
- Header 00 00 -> done=1 and cpu_rst_n=1 with zero writes (without the feature; with the feature, checksum byte 00 is required).
- With IMEM_LOADER_CHECKSUM_EN, frame 00 01 11 22 33 44:
  - Checksum byte 0x45 -> done=1.
  - Checksum byte 0x00 -> error=1, cpu_rst_n=0.
- Assert rst low after 5 bytes of a 2-word frame -> all outputs at reset values immediately; a fresh full frame then loads correctly.
